// File: rtl/wb_byte_master_pkg.sv
// Shared types and defaults for the Wishbone byte master: FSM state encoding and default data width.
package wb_byte_master_pkg;

  localparam int DSIZE_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_RDCAP = 2'd2,
    ST_RSP   = 2'd3
  } state_t;

endpackage

// File: rtl/wb_byte_master_if.sv
// Command stream, response stream and Wishbone bus of the byte master, bundled as one interface.
interface wb_byte_master_if
  import wb_byte_master_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEFAULT
);
  logic             cmd_valid;
  logic             cmd_we;
  logic [DSIZE-1:0] cmd_dat;
  logic             cmd_ready;
  logic             rsp_valid;
  logic [DSIZE-1:0] rsp_dat;
  logic             rsp_err;
  logic             rsp_ready;
  logic             stb;
  logic             we;
  logic [DSIZE-1:0] wdat;
  logic             ack;
  logic [DSIZE-1:0] rdat;

  // The master view belongs to wb_byte_master; the slave view is everything around it.
  modport master (
    input  cmd_valid, cmd_we, cmd_dat, rsp_ready, ack, rdat,
    output cmd_ready, rsp_valid, rsp_dat, rsp_err, stb, we, wdat
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_dat, rsp_ready, ack, rdat,
    input  cmd_ready, rsp_valid, rsp_dat, rsp_err, stb, we, wdat
  );
endinterface

// File: rtl/wb_byte_master_sync_fifo.sv
// Synchronous command FIFO with registered storage (no fall-through); pointers carry an extra wrap bit.
module wb_byte_master_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  // NOTE: storage is deliberately not reset; occupancy comes from the pointers alone, so stale entries are never read.
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end
endmodule

// File: rtl/wb_byte_master.sv
// Wishbone master for the byte register slave: queues write/read commands, runs one bus cycle each,
// and returns one response per command (timeout reported as err=1, dat=0).
module wb_byte_master
  import wb_byte_master_pkg::*;
#(
  parameter int DSIZE      = DSIZE_DEFAULT,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input logic               i_clk,
  input logic               i_rst_n,
  wb_byte_master_if.master  bus
);
  localparam int             CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             stb_q, stb_d;
  logic             we_q, we_d;
  logic [DSIZE-1:0] wdat_q, wdat_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [DSIZE-1:0] rsp_dat_q, rsp_dat_d;
  logic             rsp_err_q, rsp_err_d;

  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [DSIZE:0]   fifo_out;

  wb_byte_master_sync_fifo #(
    .WIDTH (DSIZE + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .push      (bus.cmd_valid),
    .push_data ({bus.cmd_we, bus.cmd_dat}),
    .pop       (fifo_pop),
    .pop_data  (fifo_out),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.cmd_ready = !fifo_full;
  assign bus.stb       = stb_q;
  assign bus.we        = we_q;
  assign bus.wdat      = wdat_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_dat   = rsp_dat_q;
  assign bus.rsp_err   = rsp_err_q;

  always_comb begin
    // NOTE: every next-value defaults to its register first, so no branch can leave one unassigned and infer a latch.
    state_d     = state_q;
    cnt_d       = cnt_q;
    stb_d       = stb_q;
    we_d        = we_q;
    wdat_d      = wdat_q;
    rsp_valid_d = rsp_valid_q;
    rsp_dat_d   = rsp_dat_q;
    rsp_err_d   = rsp_err_q;
    fifo_pop    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          we_d     = fifo_out[DSIZE];
          wdat_d   = fifo_out[DSIZE-1:0];
          stb_d    = 1'b1;
          cnt_d    = '0;
          state_d  = ST_BUS;
        end
      end
      ST_BUS: begin
        // An ack arriving on the last allowed cycle still completes the transfer normally.
        if (bus.ack) begin
          stb_d = 1'b0;
          if (we_q) begin
            rsp_dat_d   = wdat_q;
            rsp_err_d   = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = ST_RSP;
          end else begin
            state_d = ST_RDCAP;
          end
        end else if (cnt_q == CNT_LAST) begin
          stb_d       = 1'b0;
          rsp_dat_d   = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RSP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RDCAP: begin
        // The slave presents read data one cycle after its ack.
        rsp_dat_d   = bus.rdat;
        rsp_err_d   = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = ST_RSP;
      end
      ST_RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      wdat_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      wdat_q      <= wdat_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_dat_q   <= rsp_dat_d;
      rsp_err_q   <= rsp_err_d;
    end
  end
endmodule
